// File: rtl/calc_core.sv
// Calculator datapath/control: decimal operand entry, add/sub/mul/div on '='.
// Define CALC_DIV_EN to build the restoring divider and divide-by-zero error path.
module calc_core #(
    parameter int MAX_DIGITS = 4,
    parameter int OPW        = 14
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              key_down,
    input  logic [3:0]        key_value,
    output logic [2*OPW-1:0]  disp_value,
    output logic              disp_neg,
    output logic              disp_err,
    output logic              disp_valid,
    output logic              busy
);

    localparam int RW = 2 * OPW;
    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {ENTA, ENTB, CALC, DONE, ERR} state_t;

    state_t         state;
    logic [OPW-1:0] a, b;
    logic [CW-1:0]  cnt;
    logic [1:0]     op;

    logic           k_digit, k_op, k_clr, k_eq;
    logic [3:0]     k_d;
    logic [1:0]     k_opc;

    logic [OPW-1:0] acc_src, acc_nx;
    logic [OPW+3:0] acc_t;
    logic [RW-1:0]  sum_r, prod_r;
    logic [OPW-1:0] diff_ab, diff_ba;
    logic           a_ge_b, room;

    always_comb begin
        k_digit = 1'b0;
        k_op    = 1'b0;
        k_clr   = 1'b0;
        k_eq    = 1'b0;
        k_d     = 4'd0;
        k_opc   = 2'd0;
        if (key_down) begin
            case (key_value)
                4'd0:  begin k_digit = 1'b1; k_d = 4'd1; end
                4'd1:  begin k_digit = 1'b1; k_d = 4'd2; end
                4'd2:  begin k_digit = 1'b1; k_d = 4'd3; end
                4'd4:  begin k_digit = 1'b1; k_d = 4'd4; end
                4'd5:  begin k_digit = 1'b1; k_d = 4'd5; end
                4'd6:  begin k_digit = 1'b1; k_d = 4'd6; end
                4'd8:  begin k_digit = 1'b1; k_d = 4'd7; end
                4'd9:  begin k_digit = 1'b1; k_d = 4'd8; end
                4'd10: begin k_digit = 1'b1; k_d = 4'd9; end
                4'd13: begin k_digit = 1'b1; k_d = 4'd0; end
                4'd3:  begin k_op = 1'b1; k_opc = 2'd0; end
                4'd7:  begin k_op = 1'b1; k_opc = 2'd1; end
                4'd11: begin k_op = 1'b1; k_opc = 2'd2; end
`ifdef CALC_DIV_EN
                4'd15: begin k_op = 1'b1; k_opc = 2'd3; end
`endif
                4'd12: k_clr = 1'b1;
                4'd14: k_eq  = 1'b1;
                default: ;
            endcase
        end
    end

    // Shared accumulator: x*10 + d as (x<<3) + (x<<1) + d
    always_comb begin
        acc_src = (state == ENTB) ? b : a;
        acc_t   = {1'b0, acc_src, 3'b000} + {3'b000, acc_src, 1'b0}
                + {{OPW{1'b0}}, k_d};
        acc_nx  = acc_t[OPW-1:0];
        room    = (cnt < CW'(MAX_DIGITS));
    end

    always_comb begin
        sum_r   = RW'(a) + RW'(b);
        prod_r  = RW'(a) * RW'(b);
        diff_ab = a - b;
        diff_ba = b - a;
        a_ge_b  = (a >= b);
    end

`ifdef CALC_DIV_EN
    localparam int IW = $clog2(OPW + 1);

    logic           err_q;
    logic [OPW-1:0] dq, dr;
    logic [IW-1:0]  dcnt;
    logic [OPW:0]   rsh, rsub;

    // rsub[OPW] set means the trial subtraction borrowed: restore
    always_comb begin
        rsh  = {dr, dq[OPW-1]};
        rsub = rsh - {1'b0, b};
    end

    assign disp_err = err_q;
`else
    assign disp_err = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state      <= ENTA;
            a          <= '0;
            b          <= '0;
            cnt        <= '0;
            op         <= 2'd0;
            disp_value <= '0;
            disp_neg   <= 1'b0;
            disp_valid <= 1'b0;
            busy       <= 1'b0;
`ifdef CALC_DIV_EN
            err_q      <= 1'b0;
            dq         <= '0;
            dr         <= '0;
            dcnt       <= '0;
`endif
        end else begin
            disp_valid <= 1'b0;
            if (k_clr) begin
                state      <= ENTA;
                a          <= '0;
                b          <= '0;
                cnt        <= '0;
                op         <= 2'd0;
                disp_value <= '0;
                disp_neg   <= 1'b0;
                disp_valid <= 1'b1;
                busy       <= 1'b0;
`ifdef CALC_DIV_EN
                err_q      <= 1'b0;
`endif
            end else begin
                case (state)
                    ENTA: begin
                        if (k_digit && room) begin
                            a          <= acc_nx;
                            cnt        <= cnt + 1'b1;
                            disp_value <= RW'(acc_nx);
                            disp_valid <= 1'b1;
                        end else if (k_op) begin
                            op         <= k_opc;
                            b          <= '0;
                            cnt        <= '0;
                            disp_valid <= 1'b1;
                            state      <= ENTB;
                        end
                    end
                    ENTB: begin
                        if (k_digit && room) begin
                            b          <= acc_nx;
                            cnt        <= cnt + 1'b1;
                            disp_value <= RW'(acc_nx);
                            disp_valid <= 1'b1;
                        end else if (k_op && cnt == '0) begin
                            op <= k_opc;
                        end else if (k_eq) begin
                            busy  <= 1'b1;
                            state <= CALC;
`ifdef CALC_DIV_EN
                            dq    <= a;
                            dr    <= '0;
                            dcnt  <= '0;
`endif
                        end
                    end
                    CALC: begin
                        case (op)
                            2'd0: begin
                                disp_value <= sum_r;
                                disp_neg   <= 1'b0;
                                disp_valid <= 1'b1;
                                busy       <= 1'b0;
                                state      <= DONE;
                            end
                            2'd1: begin
                                disp_value <= RW'(a_ge_b ? diff_ab : diff_ba);
                                disp_neg   <= ~a_ge_b;
                                disp_valid <= 1'b1;
                                busy       <= 1'b0;
                                state      <= DONE;
                            end
                            2'd2: begin
                                disp_value <= prod_r;
                                disp_neg   <= 1'b0;
                                disp_valid <= 1'b1;
                                busy       <= 1'b0;
                                state      <= DONE;
                            end
                            default: begin
`ifdef CALC_DIV_EN
                                if (b == '0) begin
                                    err_q      <= 1'b1;
                                    disp_value <= '0;
                                    disp_neg   <= 1'b0;
                                    disp_valid <= 1'b1;
                                    busy       <= 1'b0;
                                    state      <= ERR;
                                end else if (dcnt != IW'(OPW)) begin
                                    dq   <= {dq[OPW-2:0], ~rsub[OPW]};
                                    dr   <= rsub[OPW] ? rsh[OPW-1:0]
                                                      : rsub[OPW-1:0];
                                    dcnt <= dcnt + 1'b1;
                                end else begin
                                    disp_value <= RW'(dq);
                                    disp_neg   <= 1'b0;
                                    disp_valid <= 1'b1;
                                    busy       <= 1'b0;
                                    state      <= DONE;
                                end
`else
                                busy  <= 1'b0;
                                state <= DONE;
`endif
                            end
                        endcase
                    end
                    DONE: begin
                        if (k_digit) begin
                            a          <= OPW'(k_d);
                            cnt        <= CW'(1);
                            disp_value <= RW'(k_d);
                            disp_neg   <= 1'b0;
                            disp_valid <= 1'b1;
                            state      <= ENTA;
                        end
                    end
                    ERR: ;
                    default: state <= ENTA;
                endcase
            end
        end
    end

endmodule
